score_mat_collector: RTL and testbench

//   Stage directly upstream of the row-wise matrix softmax. Accepts the attention

---
 rtl/score_mat_collector_if.sv | 44 ++++
 rtl/score_mat_collector.sv | 119 +++++++++++
 tb/tb_score_mat_collector.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_mat_collector_if.sv
// ---------------------------------------------------------------------------
// score_mat_collector_if
//   Bundles the row-input stream and the packed-matrix output stream of the
//   score matrix collector.
//
//   Handshake semantics (both streams): a transfer happens on a rising clk
//   edge where valid and ready are both 1. The producer holds its payload
//   and valid steady until that edge. The consumer may drive ready
//   independently of valid.
//
//   Signals
//     in_row    master->slave  one score row, element j at [W*(j+1)-1:W*j]
//     in_valid  master->slave  in_row/in_last valid
//     in_last   master->slave  final row of the current matrix
//     in_ready  slave->master  collector can accept a row
//     out_mat   slave->master  packed matrix, row i at [W*C*(i+1)-1:W*C*i]
//     out_valid slave->master  out_mat holds a complete matrix
//     out_ready master->slave  downstream accepts out_mat
//     err_len   slave->master  sticky matrix-length error flag
// ---------------------------------------------------------------------------
interface score_mat_collector_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ROW_IN     = 8,
    parameter int COL_IN     = 8
);
    logic [DATA_WIDTH*COL_IN-1:0]        in_row;
    logic                                in_valid;
    logic                                in_last;
    logic                                in_ready;
    logic [DATA_WIDTH*ROW_IN*COL_IN-1:0] out_mat;
    logic                                out_valid;
    logic                                out_ready;
    logic                                err_len;

    modport master (
        output in_row, in_valid, in_last, out_ready,
        input  in_ready, out_mat, out_valid, err_len
    );

    modport slave (
        input  in_row, in_valid, in_last, out_ready,
        output in_ready, out_mat, out_valid, err_len
    );
endinterface

// File: rtl/score_mat_collector.sv
// ---------------------------------------------------------------------------
// score_mat_collector
//   Collects an attention score matrix one row per beat, scales every element
//   by 2^-SCALE_SHIFT (arithmetic shift, rounds toward -inf), and presents the
//   whole packed matrix to the row-wise softmax. Rows that were never
//   delivered read as the most negative value so they carry ~0 softmax weight.
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous active-high reset
//     bus          score_mat_collector_if.slave (row input, matrix output,
//                  sticky err_len)
//     dbg_state_o  FSM state: 0 = FILL (collecting rows), 1 = FULL (presenting)
// ---------------------------------------------------------------------------
module score_mat_collector #(
    parameter int DATA_WIDTH  = 16,
    parameter int ROW_IN      = 8,
    parameter int COL_IN      = 8,
    parameter int SCALE_SHIFT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    score_mat_collector_if.slave bus,
    output logic                 dbg_state_o
);
    localparam int ROW_W = DATA_WIDTH * COL_IN;
    localparam int CNT_W = (ROW_IN > 1) ? $clog2(ROW_IN) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROW_IN - 1);
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                       state_q;
    logic [CNT_W-1:0]             row_cnt_q;
    logic [ROW_IN-1:0]            row_mask_q;
    logic [ROW_IN-1:0][ROW_W-1:0] buffer_q;
    logic                         in_ready_q;
    logic                         out_valid_q;
    logic                         err_len_q;

    logic [ROW_W-1:0]             scaled_row_d;
    logic                         at_last_row_d;
    logic                         close_d;
    logic                         len_err_d;

    // Element-wise signed shift of the incoming row.
    always_comb begin
        scaled_row_d = '0;
        for (int j = 0; j < COL_IN; j++) begin
            scaled_row_d[j*DATA_WIDTH +: DATA_WIDTH] =
                $signed(bus.in_row[j*DATA_WIDTH +: DATA_WIDTH]) >>> SCALE_SHIFT;
        end
    end

    // A matrix closes on in_last or when the buffer is full, whichever is
    // first. The length is wrong exactly when those two disagree.
    assign at_last_row_d = (row_cnt_q == LAST_ROW);
    assign close_d       = bus.in_last || at_last_row_d;
    assign len_err_d     = bus.in_last != at_last_row_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            row_cnt_q   <= '0;
            row_mask_q  <= '0;
            buffer_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (bus.in_valid && in_ready_q) begin
                        buffer_q[row_cnt_q]   <= scaled_row_d;
                        row_mask_q[row_cnt_q] <= 1'b1;
                        if (close_d) begin
                            state_q     <= FULL;
                            row_cnt_q   <= '0;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            if (len_err_d) begin
                                err_len_q <= 1'b1;
                            end
                        end else begin
                            row_cnt_q <= row_cnt_q + CNT_W'(1);
                        end
                    end
                end
                FULL: begin
                    // Only the mask is cleared; stale buffer rows are hidden
                    // behind it until overwritten.
                    if (bus.out_ready) begin
                        state_q     <= FILL;
                        row_mask_q  <= '0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    // Undelivered rows read as MIN in every element.
    always_comb begin
        bus.out_mat = '0;
        for (int i = 0; i < ROW_IN; i++) begin
            bus.out_mat[i*ROW_W +: ROW_W] = row_mask_q[i] ? buffer_q[i] : {COL_IN{MIN_VAL}};
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err_len   = err_len_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_score_mat_collector.sv
module tb_score_mat_collector;
    localparam int W     = 16;
    localparam int R     = 8;
    localparam int C     = 8;
    localparam int S     = 2;
    localparam int ROW_W = W * C;
    localparam int MAT_W = ROW_W * R;
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    typedef struct {
        logic [W-1:0] in_v;
        logic [W-1:0] exp_v;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dbg_state;

    int total = 0;
    int bad   = 0;

    // Reference model state: rows of the matrix being assembled (as ints),
    // expected sticky error, queue of expected output matrices.
    int               m_rows;
    int               m_vals[R][C];
    logic             exp_err;
    logic [MAT_W-1:0] exp_q[$];

    vec_t tbl[8];

    score_mat_collector_if #(.DATA_WIDTH(W), .ROW_IN(R), .COL_IN(C)) bus ();

    score_mat_collector #(
        .DATA_WIDTH(W), .ROW_IN(R), .COL_IN(C), .SCALE_SHIFT(S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, got no finish want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checks ----------------
    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_mat(input string name, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
        int first;
        total++;
        if (act !== exp) begin
            bad++;
            first = -1;
            for (int k = 0; k < R*C; k++) begin
                if (first < 0 && act[k*W +: W] !== exp[k*W +: W]) first = k;
            end
            if (first < 0) first = 0;
            $display("FAIL %s: elem r%0d c%0d got %h want %h", name, first / C, first % C,
                     act[first*W +: W], exp[first*W +: W]);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int floor_shift(input int v);
        int d;
        d = 1 << S;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    task automatic model_reset();
        m_rows  = 0;
        exp_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_beat(input logic [ROW_W-1:0] row, input logic last);
        logic [MAT_W-1:0] mat;
        logic [W-1:0]     e;
        int               v;
        for (int j = 0; j < C; j++) begin
            v = $signed(row[j*W +: W]);
            m_vals[m_rows][j] = floor_shift(v);
        end
        m_rows++;
        if (last || m_rows == R) begin
            if (!(last && m_rows == R)) exp_err = 1'b1;
            for (int i = 0; i < R; i++) begin
                for (int j = 0; j < C; j++) begin
                    if (i < m_rows) begin
                        v = m_vals[i][j];
                        e = v[W-1:0];
                    end else begin
                        e = MIN_VAL;
                    end
                    mat[(i*C+j)*W +: W] = e;
                end
            end
            exp_q.push_back(mat);
            m_rows = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [ROW_W-1:0] rand_row();
        logic [ROW_W-1:0] r;
        for (int j = 0; j < C; j++) begin
            case ($urandom_range(0, 7))
                0:       r[j*W +: W] = MIN_VAL;
                1:       r[j*W +: W] = {W{1'b1}};
                default: r[j*W +: W] = W'($urandom);
            endcase
        end
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] lin_row(input int i);
        logic [ROW_W-1:0] r;
        for (int j = 0; j < C; j++) r[j*W +: W] = W'(16 * i + j);
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] const_row(input logic [W-1:0] v);
        return {C{v}};
    endfunction

    function automatic logic [MAT_W-1:0] const_mat(input logic [W-1:0] v);
        return {(R*C){v}};
    endfunction

    // Called and returns just after a falling edge.
    task automatic send_row(input logic [ROW_W-1:0] row, input logic last);
        int g;
        bus.in_row   = row;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        g = 0;
        while (bus.in_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            total++;
            bad++;
            $display("FAIL send_row: in_ready got %b want 1", bus.in_ready);
        end else begin
            model_beat(row, last);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic cmp_front(input string name);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: out_valid got 1 want 0 (no matrix expected)", name);
        end else begin
            check_mat(name, bus.out_mat, exp_q[0]);
        end
    endtask

    task automatic check_and_accept(input string name);
        check_bit({name, "_valid"}, bus.out_valid, 1'b1);
        cmp_front({name, "_mat"});
        check_bit({name, "_err"}, bus.err_len, exp_err);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        check_bit({name, "_rel_valid"}, bus.out_valid, 1'b0);
        check_bit({name, "_rel_ready"}, bus.in_ready, 1'b1);
    endtask

    // Asserts rst between clock edges and checks the outputs before any edge.
    task automatic async_reset_check(input string name);
        #2 rst = 1'b1;
        #1;
        check_bit({name, "_in_ready"}, bus.in_ready, 1'b1);
        check_bit({name, "_out_valid"}, bus.out_valid, 1'b0);
        check_bit({name, "_err"}, bus.err_len, 1'b0);
        check_bit({name, "_dbg"}, dbg_state, 1'b0);
        check_mat({name, "_mat"}, bus.out_mat, const_mat(MIN_VAL));
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [MAT_W-1:0] e2;
        logic [MAT_W-1:0] saved;
        logic [ROW_W-1:0] row0;
        logic [ROW_W-1:0] rows6[24];
        int               b;
        int               seen;
        int               cyc6;
        int               pulse[3];
        bit               pend;

        tbl[0] = '{16'hFFF9, 16'hFFFE};
        tbl[1] = '{16'h8000, 16'hE000};
        tbl[2] = '{16'h7FFF, 16'h1FFF};
        tbl[3] = '{16'h0001, 16'h0000};
        tbl[4] = '{16'hFFFF, 16'hFFFF};
        tbl[5] = '{16'h0007, 16'h0001};
        tbl[6] = '{16'hFFFC, 16'hFFFF};
        tbl[7] = '{16'hFFFB, 16'hFFFE};

        bus.in_row    = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();

        // Power-on reset, checked before the first clock edge.
        #1 rst = 1'b1;
        #1;
        check_bit("rst0_in_ready", bus.in_ready, 1'b1);
        check_bit("rst0_out_valid", bus.out_valid, 1'b0);
        check_bit("rst0_err", bus.err_len, 1'b0);
        check_bit("rst0_dbg", dbg_state, 1'b0);
        check_mat("rst0_mat", bus.out_mat, const_mat(MIN_VAL));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full 8-row matrix, element(i,j) = 16*i+j.
        for (int i = 0; i < R; i++) send_row(lin_row(i), i == R - 1);
        check_bit("t2_latency", bus.out_valid, 1'b1);
        check_bit("t2_dbg_full", dbg_state, 1'b1);
        check_bit("t2_in_ready", bus.in_ready, 1'b0);
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) e2[(i*C+j)*W +: W] = W'(4 * i + (j >> 2));
        check_mat("t2_const", bus.out_mat, e2);
        check_val("t2_r7c7", bus.out_mat[(7*C+7)*W +: W], 16'd29);
        check_and_accept("t2");

        // Sign handling table: whole matrix of one value.
        for (int t = 0; t < 8; t++) begin
            for (int r = 0; r < R; r++) send_row(const_row(tbl[t].in_v), r == R - 1);
            check_mat("t3_sign", bus.out_mat, const_mat(tbl[t].exp_v));
            check_and_accept("t3");
        end

        // Back-to-back: in_valid and out_ready held high over 3 matrices.
        for (int k = 0; k < 24; k++) rows6[k] = rand_row();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_row    = rows6[0];
        bus.in_last   = 1'b0;
        b = 0; seen = 0; cyc6 = 0; pend = 1'b0;
        while (seen < 3 && cyc6 < 100) begin
            if (pend) begin
                b++;
                if (b < 24) begin
                    bus.in_row  = rows6[b];
                    bus.in_last = (b % 8 == 7);
                end else begin
                    bus.in_valid = 1'b0;
                    bus.in_last  = 1'b0;
                end
            end
            if (bus.out_valid === 1'b1) begin
                pulse[seen] = cyc6;
                cmp_front("t6_mat");
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                seen++;
            end
            pend = bus.in_valid && (bus.in_ready === 1'b1);
            if (pend) model_beat(bus.in_row, bus.in_last);
            @(negedge clk);
            cyc6++;
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        check_int("t6_count", seen, 3);
        if (seen == 3) begin
            check_int("t6_gap1", pulse[1] - pulse[0], R + 1);
            check_int("t6_gap2", pulse[2] - pulse[1], R + 1);
        end
        check_bit("t6_err", bus.err_len, 1'b0);

        // Backpressure: out_ready low for 10 cycles with a row waiting.
        for (int r = 0; r < R; r++) send_row(rand_row(), r == R - 1);
        saved = (exp_q.size() > 0) ? exp_q[0] : '0;
        row0 = rand_row();
        bus.in_row   = row0;
        bus.in_last  = 1'b0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_bit("t5_hold_ready", bus.in_ready, 1'b0);
            check_bit("t5_hold_valid", bus.out_valid, 1'b1);
            check_mat("t5_hold_mat", bus.out_mat, saved);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        check_bit("t5_release_ready", bus.in_ready, 1'b1);
        check_bit("t5_release_valid", bus.out_valid, 1'b0);
        model_beat(row0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int r = 1; r < R; r++) send_row(rand_row(), r == R - 1);
        check_and_accept("t5_next");

        // Early in_last on row 2.
        for (int r = 0; r < 3; r++) send_row(lin_row(r), r == 2);
        check_val("t4_r2c5", bus.out_mat[(2*C+5)*W +: W], 16'd9);
        check_val("t4_r3c0", bus.out_mat[(3*C)*W +: W], MIN_VAL);
        check_val("t4_r7c7", bus.out_mat[(7*C+7)*W +: W], MIN_VAL);
        check_bit("t4_err_set", bus.err_len, 1'b1);
        check_and_accept("t4");
        for (int r = 0; r < R; r++) send_row(rand_row(), r == R - 1);
        check_bit("t4_sticky", bus.err_len, 1'b1);
        check_and_accept("t4_after");

        // Eight rows without in_last close the matrix anyway.
        for (int r = 0; r < R; r++) send_row(rand_row(), 1'b0);
        check_bit("t4_nolast_valid", bus.out_valid, 1'b1);
        check_and_accept("t4_nolast");

        // Reset while presenting a matrix with err_len set.
        for (int r = 0; r < 3; r++) send_row(rand_row(), r == 2);
        async_reset_check("rst_full");

        // Reset with a partial matrix: partial rows discarded.
        for (int r = 0; r < 3; r++) send_row(rand_row(), 1'b0);
        async_reset_check("rst_part");
        for (int r = 0; r < R; r++) send_row(rand_row(), r == R - 1);
        check_and_accept("rst_after");

        // Randomized traffic against the model.
        pend = 1'b0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            check_bit("rnd_in_ready", bus.in_ready, exp_q.size() == 0);
            check_bit("rnd_out_valid", bus.out_valid, exp_q.size() != 0);
            check_bit("rnd_err", bus.err_len, exp_err);
            if (bus.out_valid === 1'b1) cmp_front("rnd_mat");
            bus.out_ready = (cyc >= 400) || ($urandom_range(0, 2) != 0);
            if (exp_q.size() > 0 && bus.out_ready) void'(exp_q.pop_front());
            if (cyc >= 400) begin
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
            end else if (!bus.in_valid || pend) begin
                if ($urandom_range(0, 3) != 0) begin
                    bus.in_valid = 1'b1;
                    bus.in_row   = rand_row();
                    bus.in_last  = (m_rows == R - 1) ? ($urandom_range(0, 1) == 1)
                                                     : ($urandom_range(0, 9) == 0);
                end else begin
                    bus.in_valid = 1'b0;
                    bus.in_last  = 1'b0;
                end
            end
            pend = bus.in_valid && (bus.in_ready === 1'b1);
            if (pend) model_beat(bus.in_row, bus.in_last);
            @(negedge clk);
        end
        bus.out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
